// File: rtl/reset_sequencer.sv
// Power-on reset sequencer: qualifies PLL locks, stretches reset, then releases
// reset domains in order with a fixed gap, and watches for lock loss afterwards.
module reset_sequencer #(
  parameter int unsigned NUM_LOCKS      = 2,
  parameter int unsigned NUM_DOMAINS    = 3,
  parameter int unsigned LOCK_FILTER    = 16,
  parameter int unsigned STRETCH_CYCLES = 32,
  parameter int unsigned STAGE_GAP      = 8,
  parameter int unsigned BLINK_HALF     = 50_000_000
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [NUM_LOCKS-1:0]   lock_in,
  input  logic                   fault_clear,
  output logic [NUM_DOMAINS-1:0] domain_reset_n,
  output logic                   ready,
  output logic                   fault_sticky,
  output logic                   led
);

  localparam int unsigned FILT_W  = $clog2(LOCK_FILTER + 1);
  localparam int unsigned STR_W   = $clog2(STRETCH_CYCLES + 1);
  localparam int unsigned GAP_W   = $clog2(STAGE_GAP + 1);
  localparam int unsigned BLINK_W = $clog2(BLINK_HALF + 1);

  typedef enum logic [2:0] {
    WAIT_LOCK,
    STRETCH,
    RELEASE,
    RUN,
    FAULT
  } state_e;

  state_e                 state_q, state_d;
  logic [NUM_LOCKS-1:0]   sync1_q, sync1_d;
  logic [NUM_LOCKS-1:0]   sync2_q, sync2_d;
  logic [FILT_W-1:0]      filt_cnt_q, filt_cnt_d;
  logic [STR_W-1:0]       str_cnt_q, str_cnt_d;
  logic [GAP_W-1:0]       gap_cnt_q, gap_cnt_d;
  logic [BLINK_W-1:0]     blink_cnt_q, blink_cnt_d;
  logic [NUM_DOMAINS-1:0] dom_q, dom_d;
  logic                   ready_q, ready_d;
  logic                   sticky_q, sticky_d;
  logic                   led_q, led_d;
  logic                   all_locked;
  logic                   fault_set;

  assign all_locked = &sync2_q;

  // Synchronous active-low reset; every flop returns to its idle value.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= WAIT_LOCK;
      sync1_q     <= '0;
      sync2_q     <= '0;
      filt_cnt_q  <= '0;
      str_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      blink_cnt_q <= '0;
      dom_q       <= '0;
      ready_q     <= 1'b0;
      sticky_q    <= 1'b0;
      led_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      filt_cnt_q  <= filt_cnt_d;
      str_cnt_q   <= str_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      dom_q       <= dom_d;
      ready_q     <= ready_d;
      sticky_q    <= sticky_d;
      led_q       <= led_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sync1_d     = lock_in;
    sync2_d     = sync1_q;
    filt_cnt_d  = filt_cnt_q;
    str_cnt_d   = str_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    blink_cnt_d = blink_cnt_q;
    dom_d       = dom_q;
    ready_d     = ready_q;
    led_d       = led_q;
    fault_set   = 1'b0;

    case (state_q)
      WAIT_LOCK: begin
        dom_d   = '0;
        ready_d = 1'b0;
        led_d   = 1'b0;
        // Any low lock only restarts the filter here; it is never a fault.
        if (!all_locked) begin
          filt_cnt_d = '0;
        end else if (filt_cnt_q == FILT_W'(LOCK_FILTER - 1)) begin
          filt_cnt_d = '0;
          str_cnt_d  = '0;
          state_d    = STRETCH;
        end else begin
          filt_cnt_d = filt_cnt_q + FILT_W'(1);
        end
      end

      STRETCH: begin
        if (!all_locked) begin
          fault_set = 1'b1;
        end else if (str_cnt_q == STR_W'(STRETCH_CYCLES - 1)) begin
          str_cnt_d = '0;
          gap_cnt_d = '0;
          dom_d     = NUM_DOMAINS'(1);
          if (NUM_DOMAINS == 1) begin
            state_d     = RUN;
            ready_d     = 1'b1;
            blink_cnt_d = '0;
            led_d       = 1'b0;
          end else begin
            state_d = RELEASE;
          end
        end else begin
          str_cnt_d = str_cnt_q + STR_W'(1);
        end
      end

      RELEASE: begin
        if (!all_locked) begin
          fault_set = 1'b1;
        end else if (gap_cnt_q == GAP_W'(STAGE_GAP - 1)) begin
          gap_cnt_d = '0;
          // Shift in one more released domain above those already high.
          dom_d     = NUM_DOMAINS'({dom_q, 1'b1});
          if (&dom_d) begin
            state_d     = RUN;
            ready_d     = 1'b1;
            blink_cnt_d = '0;
            led_d       = 1'b0;
          end
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end

      RUN: begin
        if (!all_locked) begin
          fault_set = 1'b1;
        end else if (blink_cnt_q == BLINK_W'(BLINK_HALF - 1)) begin
          blink_cnt_d = '0;
          led_d       = ~led_q;
        end else begin
          blink_cnt_d = blink_cnt_q + BLINK_W'(1);
        end
      end

      FAULT: begin
        filt_cnt_d = '0;
        state_d    = WAIT_LOCK;
      end

      default: begin
        state_d = WAIT_LOCK;
      end
    endcase

    if (fault_set) begin
      state_d     = FAULT;
      dom_d       = '0;
      ready_d     = 1'b0;
      led_d       = 1'b0;
      blink_cnt_d = '0;
      str_cnt_d   = '0;
      gap_cnt_d   = '0;
    end

    // A fault on the same edge as a clear request keeps the flag set.
    sticky_d = fault_set | (sticky_q & ~fault_clear);
  end

  assign domain_reset_n = dom_q;
  assign ready          = ready_q;
  assign fault_sticky   = sticky_q;
  assign led            = led_q;

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 SHALL have parameter NUM_LOCKS, default 2, meaning the number of PLL lock inputs (legal range 1..4).
REQ-002 SHALL have parameter NUM_DOMAINS, default 3, meaning the number of sequenced reset outputs (legal range 1..8).
REQ-003 SHALL have parameter LOCK_FILTER, default 16, meaning the number of consecutive cycles all synced locks must be high (minimum 1).
REQ-004 SHALL have parameter STRETCH_CYCLES, default 32, meaning the reset hold after lock qualification (minimum 1).
REQ-005 SHALL have parameter STAGE_GAP, default 8, meaning the cycles between consecutive domain releases (minimum 1).
REQ-006 SHALL have parameter BLINK_HALF, default 50_000_000, meaning the cycles per LED level in RUN (minimum 2).
REQ-007 SHALL have port clock, input, 1, the single clock; all logic is on its rising edge.
REQ-008 SHALL have port reset_n, input, 1, the synchronous, active-low reset.
REQ-009 SHALL have port lock_in, input, NUM_LOCKS, PLL lock flags, asynchronous to clock.
REQ-010 SHALL have port fault_clear, input, 1, a single-cycle pulse that clears fault_sticky.
REQ-011 SHALL have port domain_reset_n, output, NUM_DOMAINS, registered active-low resets, bit 0 released first.
REQ-012 SHALL have port ready, output, 1, registered, high only in RUN.
REQ-013 SHALL have port fault_sticky, output, 1, registered, set on lock loss after qualification.
REQ-014 SHALL have port led, output, 1, registered status LED.

Function
REQ-015 SHALL pass each lock_in bit through a 2-flop synchronizer; all decisions use synced values only.
REQ-016 SHALL implement states WAIT_LOCK, STRETCH, RELEASE, RUN and FAULT.
REQ-017 SHALL, in WAIT_LOCK, count cycles with all synced locks high, zero the count whenever any synced lock is low, and move to STRETCH once the count reaches LOCK_FILTER.
REQ-018 SHALL hold all domain_reset_n low in WAIT_LOCK and STRETCH, remain in STRETCH for STRETCH_CYCLES cycles, then enter RELEASE.
REQ-019 SHALL raise domain_reset_n[0] exactly 2+LOCK_FILTER+STRETCH_CYCLES edges after the first edge that samples lock_in all-high, provided lock_in stays all-high (defaults: 50).
REQ-020 SHALL raise domain_reset_n[i+1] exactly STAGE_GAP edges after domain_reset_n[i]; released bits stay high until a fault or reset.
REQ-021 SHALL enter RUN and raise ready on the same edge that releases domain_reset_n[NUM_DOMAINS-1]; with NUM_DOMAINS=1 this is the same edge as domain_reset_n[0].
REQ-022 SHALL, if any synced lock is low in STRETCH, RELEASE or RUN, enter FAULT; on that edge all domain_reset_n and ready go low and fault_sticky goes high. This edge is the 3rd edge after the first edge that samples the lock low.
REQ-023 SHALL leave FAULT for WAIT_LOCK unconditionally one cycle later, with the filter counter zeroed.
REQ-024 SHALL treat a lock drop during WAIT_LOCK only as a filter-count restart, never as a fault.
REQ-025 SHALL clear fault_sticky on fault_clear; if a fault set and fault_clear occur on the same edge, set wins.
REQ-026 SHALL hold led low outside RUN.
REQ-027 SHALL, in RUN, toggle led every BLINK_HALF cycles, starting from led=0 with the blink counter zeroed on RUN entry; the first toggle occurs BLINK_HALF edges after entry.
REQ-028 SHALL size every counter to $clog2 of its maximum value plus 1, and no counter shall wrap within a state.

Reset
REQ-029 SHALL, while reset_n is low at an edge, set: state WAIT_LOCK; all counters 0; synchronizer flops 0; domain_reset_n all 0; ready 0; fault_sticky 0; led 0.
REQ-030 SHALL, on reset_n assertion mid-sequence (any state), reach the reset values on that same edge with no partial release.
REQ-031 SHALL restart sequencing from WAIT_LOCK after reset_n deassertion, with full filter and stretch delays.

Verification
REQ-032 Bench SHALL use defaults, with both locks high from edge 1 after reset release: domain_reset_n = 3'b001 at edge 50, 3'b011 at edge 58, 3'b111 and ready=1 at edge 66.
REQ-033 Bench SHALL glitch lock_in[1] low for 1 cycle at edge 10: the filter restarts, and domain_reset_n[0] rises 2+16+32 edges after the glitch ends.
REQ-034 Bench SHALL drop lock_in[0] in RUN: on the 3rd edge domain_reset_n=0, ready=0 and fault_sticky=1; once the lock returns, the full sequence re-runs and fault_sticky stays 1.
REQ-035 Bench SHALL pulse fault_clear on the same edge a fault is set: fault_sticky=1; a later lone pulse gives fault_sticky=0.
REQ-036 Bench SHALL assert reset_n low during RELEASE with domain_reset_n=3'b001: 3'b000 on that edge, and the sequence restarts after release.
REQ-037 Bench SHALL set BLINK_HALF=4 and hold RUN: led goes 0 to 1 at 4 edges after RUN entry and back to 0 at 8 edges.
